// File: rtl/pzhsbus_slicer_pkg.sv
// Shared helpers for the hsbus multi-lane register slicer: counter sizing,
// per-stage depth and lane slicing of packed multi-lane buses.
package pzhsbus_slicer_pkg;

  // Number of beats one stage can hold: skid stages hold two, simple stages one.
  function automatic int stage_depth(input int full_bw);
    return (full_bw != 0) ? 2 : 1;
  endfunction

  // Width of a per-lane occupancy counter; never narrower than one bit so the
  // pass-through build still has a legal (constant zero) count port.
  function automatic int calc_count_width(input int stages, input int full_bw);
    int depth;
    depth = stages * stage_depth(full_bw);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // LSB of lane 'lane' inside a packed bus of 'width'-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pzhsbus_slicer_stage.sv
// One register stage of one hsbus lane. FULL_BANDWIDTH=1 builds a main+skid
// pair whose upstream ready comes straight from a flop; FULL_BANDWIDTH=0
// builds a single register that alternates between accepting and emitting.
module pzhsbus_slicer_stage
  import pzhsbus_slicer_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int FULL_BANDWIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  if (FULL_BANDWIDTH != 0) begin : g_full
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire;
    logic             main_free;

    // Ready depends only on the skid flop, so no path from i_ready to o_ready.
    assign o_ready   = ~skid_valid_q;
    assign in_fire   = i_valid & ~skid_valid_q;
    assign main_free = ~main_valid_q | i_ready;
    assign o_valid   = main_valid_q;
    assign o_data    = main_data_q;

    // Next-state: refill main from skid first (older beat), else from input;
    // a beat arriving while main is stuck parks in skid.
    always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (main_free) begin
        if (skid_valid_q) begin
          main_valid_d = 1'b1;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = in_fire;
          if (in_fire) begin
            main_data_d = i_data;
          end
        end
      end else if (in_fire) begin
        skid_valid_d = 1'b1;
        skid_data_d  = i_data;
      end
    end

    // Valid flags clear on reset or flush; payload flops are never reset.
    always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
        main_valid_q <= 1'b0;
        skid_valid_q <= 1'b0;
      end else begin
        main_valid_q <= main_valid_d;
        skid_valid_q <= skid_valid_d;
      end
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end else begin : g_half
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             in_fire;

    assign o_ready = ~valid_q;
    assign in_fire = i_valid & ~valid_q;
    assign o_valid = valid_q;
    assign o_data  = data_q;

    // Single entry: fill when empty, drain when downstream takes it.
    always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
        valid_q <= 1'b0;
      end else if (in_fire) begin
        valid_q <= 1'b1;
      end else if (i_ready) begin
        valid_q <= 1'b0;
      end
      if (in_fire) begin
        data_q <= i_data;
      end
    end
  end

endmodule

// File: rtl/pzhsbus_multi_slicer.sv
// Multi-lane hsbus register slicer: STAGES register stages on each of
// CHANNELS independent lanes, with flush, per-lane occupancy and idle.
//
// Handshake: a beat moves across an interface at a rising edge where valid
// and ready are both high; valid never waits for ready, and a presented beat
// keeps its payload unchanged until it is taken (or dropped by flush/reset).
module pzhsbus_multi_slicer
  import pzhsbus_slicer_pkg::*;
#(
  parameter  int CHANNELS       = 1,
  parameter  int WIDTH          = 32,
  parameter  int STAGES         = 1,
  parameter  int FULL_BANDWIDTH = 1,
  localparam int CNTW           = calc_count_width(STAGES, FULL_BANDWIDTH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic [CHANNELS-1:0]      i_valid,
  output logic [CHANNELS-1:0]      o_ready,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  output logic [CHANNELS-1:0]      o_valid,
  input  logic [CHANNELS-1:0]      i_ready,
  output logic [CHANNELS*WIDTH-1:0] o_data,
  output logic [CHANNELS*CNTW-1:0] o_count,
  output logic                     o_idle
);

  localparam int MAX_COUNT = STAGES * stage_depth(FULL_BANDWIDTH);

  if (STAGES == 0) begin : g_bypass
    assign o_valid = i_valid;
    assign o_ready = i_ready;
    assign o_data  = i_data;
    assign o_count = '0;
    assign o_idle  = 1'b1;
  end else begin : g_pipe
    logic [CHANNELS-1:0] lane_busy;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      logic [STAGES:0] v;
      logic [STAGES:0] r;
      logic [WIDTH-1:0] d [STAGES+1];
      logic            accept;
      logic            pop;
      logic [CNTW-1:0] cnt_q, cnt_d;

      // Reset and flush close the input so nothing is accepted into a
      // pipeline that is being cleared in the same cycle.
      assign v[0]        = i_valid[c] & ~i_rst & ~i_flush;
      assign o_ready[c]  = r[0] & ~i_rst & ~i_flush;
      assign d[0]        = i_data[lane_lsb(c, WIDTH) +: WIDTH];
      assign r[STAGES]   = i_ready[c];
      assign o_valid[c]  = v[STAGES];
      assign o_data[lane_lsb(c, WIDTH) +: WIDTH] = d[STAGES];

      for (genvar s = 0; s < STAGES; s++) begin : g_stage
        pzhsbus_slicer_stage #(
          .WIDTH          (WIDTH),
          .FULL_BANDWIDTH (FULL_BANDWIDTH)
        ) u_stage (
          .i_clk   (i_clk),
          .i_rst   (i_rst),
          .i_flush (i_flush),
          .i_valid (v[s]),
          .o_ready (r[s]),
          .i_data  (d[s]),
          .o_valid (v[s+1]),
          .i_ready (r[s+1]),
          .o_data  (d[s+1])
        );
      end

      assign accept = v[0] & r[0];
      assign pop    = v[STAGES] & i_ready[c];

      // Occupancy next-state: accept adds a beat, pop removes one.
      always_comb begin
        cnt_d = cnt_q;
        if (accept && !pop) begin
          cnt_d = cnt_q + CNTW'(1);
        end else if (pop && !accept) begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      // Occupancy register; a pop in the flush cycle is irrelevant since it clears.
      always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Occupancy stays within the lane's capacity and never wraps below zero.
      always_ff @(posedge i_clk) begin
        if (!i_rst) begin
          assert (int'(cnt_q) <= MAX_COUNT);
          assert (!(pop && !accept && (cnt_q == '0)));
        end
      end

      assign o_count[c*CNTW +: CNTW] = cnt_q;
      assign lane_busy[c]            = |cnt_q;
    end

    assign o_idle = ~|lane_busy;
  end

endmodule

// File: tb/tb_pzhsbus_multi_slicer.sv
// Bench for the hsbus multi-lane slicer: a 4-lane 2-stage skid build and a
// 1-lane 1-stage half-bandwidth build, checked against per-lane FIFO models.
module tb_pzhsbus_multi_slicer;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int ST = 2;
  localparam int CW = 3;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, flush;
  logic [CH-1:0]   s_valid, s_ready, m_valid, m_ready;
  logic [CH*W-1:0] s_data, m_data;
  logic [CH*CW-1:0] count;
  logic            idle;

  logic         h_valid, h_ready, hm_valid, hm_ready, h_count, h_idle;
  logic [W-1:0] h_data, hm_data;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  bit exact_lat = 1'b0;
  bit mon_all_empty;

  logic [W-1:0] exp_q [CH][$];
  int           t_q   [CH][$];
  int           pop_cnt [CH];
  logic [CH-1:0] hold_v;
  logic [W-1:0] hold_d [CH];
  logic [W-1:0] hq[$];
  int           h_pops = 0;

  always @(posedge clk) cyc++;

  pzhsbus_multi_slicer #(
    .CHANNELS(CH), .WIDTH(W), .STAGES(ST), .FULL_BANDWIDTH(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_valid(s_valid), .o_ready(s_ready), .i_data(s_data),
    .o_valid(m_valid), .i_ready(m_ready), .o_data(m_data),
    .o_count(count), .o_idle(idle)
  );

  pzhsbus_multi_slicer #(
    .CHANNELS(1), .WIDTH(W), .STAGES(1), .FULL_BANDWIDTH(0)
  ) dut_h (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_valid(h_valid), .o_ready(h_ready), .i_data(h_data),
    .o_valid(hm_valid), .i_ready(hm_ready), .o_data(hm_data),
    .o_count(h_count), .o_idle(h_idle)
  );

  task automatic chk(input string name, input bit ok, input int act, input int req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
  endtask

  // ---------------- scoreboard / monitor: skid build ----------------
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      mon_all_empty = 1'b1;
      for (int c = 0; c < CH; c++) begin
        logic [W-1:0] md, exp_d;
        int t0;
        md = m_data[c*W +: W];
        chk("count", int'(count[c*CW +: CW]) == exp_q[c].size(),
            int'(count[c*CW +: CW]), exp_q[c].size());
        if (exp_q[c].size() != 0) mon_all_empty = 1'b0;
        if (hold_v[c]) chk("stall_hold", m_valid[c] && (md == hold_d[c]), int'(md), int'(hold_d[c]));
        if (m_valid[c] && m_ready[c]) begin
          if (exp_q[c].size() == 0) begin
            chk("unexpected_beat", 1'b0, int'(md), -1);
          end else begin
            exp_d = exp_q[c].pop_front();
            t0    = t_q[c].pop_front();
            chk("data", md == exp_d, int'(md), int'(exp_d));
            if (exact_lat) chk("latency", (cyc - t0) == ST, cyc - t0, ST);
            else           chk("latency_min", (cyc - t0) >= ST, cyc - t0, ST);
            pop_cnt[c]++;
          end
        end
        if (s_valid[c] && s_ready[c]) begin
          exp_q[c].push_back(s_data[c*W +: W]);
          t_q[c].push_back(cyc);
        end
        if (flush || rst) begin
          chk("ready_blocked", s_ready[c] == 1'b0, int'(s_ready[c]), 0);
          exp_q[c].delete();
          t_q[c].delete();
        end
        hold_v[c] = m_valid[c] && !m_ready[c] && !flush && !rst;
        hold_d[c] = md;
      end
      chk("idle", idle == mon_all_empty, int'(idle), int'(mon_all_empty));
    end
  end

  // ---------------- scoreboard / monitor: half-bandwidth build ----------------
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      chk("h_count", int'(h_count) == hq.size(), int'(h_count), hq.size());
      chk("h_idle", h_idle == (hq.size() == 0), int'(h_idle), int'(hq.size() == 0));
      if (hm_valid && hm_ready) begin
        if (hq.size() == 0) chk("h_unexpected_beat", 1'b0, int'(hm_data), -1);
        else begin
          logic [W-1:0] e;
          e = hq.pop_front();
          chk("h_data", hm_data == e, int'(hm_data), int'(e));
          h_pops++;
        end
      end
      if (h_valid && h_ready) hq.push_back(h_data);
      if (flush || rst) begin
        chk("h_ready_blocked", h_ready == 1'b0, int'(h_ready), 0);
        hq.delete();
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    int acc;
    logic [W-1:0] d;
    rst = 1'b1; flush = 1'b0; s_valid = '0; s_data = '0; m_ready = '0;
    h_valid = 1'b0; h_data = '0; hm_ready = 1'b0;
    hold_v = '0;
    for (int c = 0; c < CH; c++) pop_cnt[c] = 0;

    @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", s_ready == 4'hF, int'(s_ready), 15);
    chk("valid_after_reset", m_valid == 4'h0, int'(m_valid), 0);
    chk("idle_after_reset", idle == 1'b1, int'(idle), 1);
    chk("h_ready_after_reset", h_ready == 1'b1, int'(h_ready), 1);

    // Back-to-back stream on lane 0 with downstream always ready.
    m_ready = '1;
    exact_lat = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      s_valid = 4'b0001;
      s_data[0 +: W] = W'(i);
      #1 chk("stream_ready", s_ready[0] == 1'b1, int'(s_ready[0]), 1);
    end
    @(negedge clk);
    s_valid = '0;
    repeat (3) @(negedge clk);
    chk("stream_pops", pop_cnt[0] == 16, pop_cnt[0], 16);
    exact_lat = 1'b0;

    // Lane 0 stalled downstream while lane 1 streams freely.
    m_ready = 4'b1110;
    acc = 0;
    d = 8'h20;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s_valid = 4'b0011;
      s_data[0 +: W] = d;
      s_data[W +: W] = W'(8'h40 + i);
      #1 if (s_ready[0]) begin acc++; d++; end
    end
    chk("stall_accepted", acc == 4, acc, 4);
    chk("stall_ready_low", s_ready[0] == 1'b0, int'(s_ready[0]), 0);
    @(negedge clk);
    s_valid = '0;
    #1 chk("stall_count", int'(count[0 +: CW]) == 4, int'(count[0 +: CW]), 4);
    @(negedge clk);
    m_ready = '1;
    repeat (6) @(negedge clk);
    chk("stall_drained", pop_cnt[0] == 20, pop_cnt[0], 20);
    chk("lane1_unaffected", pop_cnt[1] == 6, pop_cnt[1], 6);
    chk("stall_idle", idle == 1'b1, int'(idle), 1);

    // Flush with beats in flight on lane 1 and a beat leaving lane 2.
    m_ready = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_valid = 4'b0110;
      s_data[W +: W]   = W'(8'h50 + i);
      s_data[2*W +: W] = W'(8'h60 + i);
    end
    @(negedge clk);
    flush = 1'b1;
    s_valid = 4'b0110;
    s_data[W +: W]   = 8'hAA;
    s_data[2*W +: W] = 8'h63;
    #1 chk("flush_ready_low", s_ready[1] == 1'b0, int'(s_ready[1]), 0);
    @(negedge clk);
    flush = 1'b0;
    s_valid = '0;
    #1;
    chk("flush_valid_cleared", m_valid == 4'h0, int'(m_valid), 0);
    chk("flush_count_cleared", count == '0, int'(count), 0);
    chk("flush_pop_delivered", pop_cnt[2] == 2, pop_cnt[2], 2);
    @(negedge clk);
    m_ready = '1;
    s_valid = 4'b0010;
    s_data[W +: W] = 8'hBB;
    @(negedge clk);
    s_valid = '0;
    repeat (4) @(negedge clk);
    chk("post_flush_beat", pop_cnt[1] == 7, pop_cnt[1], 7);

    // Reset mid-stream with four beats buffered on lane 3.
    m_ready = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid = 4'b1000;
      s_data[3*W +: W] = W'(8'h70 + i);
    end
    @(negedge clk);
    s_valid = '0;
    chk("reset_buffered", int'(count[3*CW +: CW]) == 4, int'(count[3*CW +: CW]), 4);
    rst = 1'b1;
    #1 chk("reset_ready_low", s_ready == 4'h0, int'(s_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_valid_cleared", m_valid == 4'h0, int'(m_valid), 0);
    chk("reset_count_cleared", count == '0, int'(count), 0);
    chk("reset_ready_back", s_ready == 4'hF, int'(s_ready), 15);
    m_ready = '1;
    @(negedge clk);
    s_valid = 4'b1000;
    s_data[3*W +: W] = 8'h7F;
    @(negedge clk);
    s_valid = '0;
    repeat (4) @(negedge clk);
    chk("post_reset_beat", pop_cnt[3] == 1, pop_cnt[3], 1);

    // Half-bandwidth build: constant valid and ready -> one beat per 2 cycles.
    acc = 0;
    d = 8'h90;
    hm_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      h_valid = 1'b1;
      h_data = d;
      #1;
      chk("h_count_alt", int'(h_count) == (i % 2), int'(h_count), i % 2);
      if (h_ready) begin acc++; d++; end
    end
    @(negedge clk);
    h_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("h_accepts", acc == 10, acc, 10);
    chk("h_pops", h_pops == 10, h_pops, 10);

    // Random traffic on all lanes of both builds, with rare flushes.
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        s_valid[c] = ($urandom_range(0, 99) < 60);
        s_data[c*W +: W] = W'($urandom);
        m_ready[c] = ($urandom_range(0, 99) < 65);
      end
      h_valid  = ($urandom_range(0, 99) < 70);
      h_data   = W'($urandom);
      hm_ready = ($urandom_range(0, 99) < 70);
      flush    = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    flush = 1'b0;
    s_valid = '0;
    h_valid = 1'b0;
    m_ready = '1;
    hm_ready = 1'b1;
    repeat (12) @(negedge clk);
    #3;
    for (int c = 0; c < CH; c++) begin
      chk("drain_empty", exp_q[c].size() == 0, exp_q[c].size(), 0);
    end
    chk("drain_idle", idle == 1'b1, int'(idle), 1);
    chk("h_drain_empty", hq.size() == 0, hq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pzhsbus_multi_slicer.md
Name: pzhsbus_multi_slicer

Overview:
- Multi-channel register slicer for the hsbus valid/ready/payload protocol.
- Inserts STAGES pipeline register stages on each of CHANNELS independent buses.
- Per build, each stage is either a 2-entry full-bandwidth skid stage or a 1-entry half-bandwidth stage.
- Adds a synchronous flush, per-channel occupancy reporting and an idle indication; used for timing closure on wide, multi-lane hsbus crossings between floorplan regions.

Parameters:
- CHANNELS, 1, number of independent hsbus lanes; must be >= 1.
- WIDTH, 32, payload bits per lane; must be >= 1.
- STAGES, 1, register stages per lane; 0 = combinational pass-through (flush and count inert).
- FULL_BANDWIDTH, 1, 1 = 2-entry skid stage (1 beat/cycle, ready registered); 0 = 1-entry stage (max 1 beat per 2 cycles).
- CNTW, $clog2(STAGES*(FULL_BANDWIDTH+1)+1), occupancy counter width (derived, not overridable).

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, synchronous reset, active-high.
- i_flush, input, 1, synchronous drop of all in-flight beats on all lanes.
- i_valid, input, CHANNELS, slave-side valid per lane.
- o_ready, output, CHANNELS, slave-side ready per lane.
- i_data, input, CHANNELS*WIDTH, slave payload; lane c at bits [c*WIDTH +: WIDTH].
- o_valid, output, CHANNELS, master-side valid per lane.
- i_ready, input, CHANNELS, master-side ready per lane.
- o_data, output, CHANNELS*WIDTH, master payload, same packing as i_data.
- o_count, output, CHANNELS*CNTW, beats held per lane.
- o_idle, output, 1, high when every lane's count is 0.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (i_rst=1 at a rising edge): all entries invalid, o_valid=0, o_count=0, o_idle=1. o_ready is forced 0 while i_rst is high, then 1 from the first cycle after release. Payload registers are not reset.
- Transfer occurs on a lane when valid&&ready at the rising edge. Lanes are fully independent: no shared back-pressure.
- Latency: a beat accepted at cycle t appears on o_valid at t+STAGES when no back-pressure is applied.
- Full-bandwidth stage:
  - main + skid register; o_ready = !skid_valid (registered).
  - Beat accepted while downstream stalls goes to main if main is empty, otherwise to skid.
  - On downstream pop, skid moves to main.
  - Sustains 1 beat/cycle; no combinational ready path through the stage.
- Half-bandwidth stage:
  - single register; ready = !valid.
  - Sustained throughput 1 beat per 2 cycles.
- Ordering is strictly FIFO per lane; payload is never modified. o_data must be held stable while o_valid=1 and i_ready=0.
- Flush:
  - i_flush=1 at an edge invalidates every entry on every lane; o_count=0 next cycle.
  - o_ready is forced 0 during the flush cycle, so no input beat is accepted.
  - A beat offered at o_valid in that cycle with i_ready=1 is still delivered (the pop precedes the clear).
  - Flush together with reset: reset dominates, with identical result.
- o_count: +1 on accept, -1 on output pop; simultaneous accept and pop leave it unchanged. Never exceeds STAGES*(FULL_BANDWIDTH+1) and never underflows; an assertion checks both.
- o_idle = NOR of all counts, combinational from the count registers.
- STAGES=0: o_valid=i_valid, o_ready=i_ready, o_data=i_data; o_count=0, o_idle=1.

Decomposition:
- Shared package pzhsbus_slicer_pkg:
  - function calc_count_width(stages, full_bw);
  - localparam-style helpers for lane slicing.
- Sub-module pzhsbus_slicer_stage: one lane, one stage.
  - Ports: valid/ready/data in and out, flush and reset.
  - Parameter FULL_BANDWIDTH.
- Top generates a CHANNELS x STAGES array of stages plus per-lane counters.

Test Plan:
- CHANNELS=2, WIDTH=8, STAGES=2, FULL_BANDWIDTH=1; lane0 streams 0x01..0x10 back-to-back with i_ready=1 -> o_valid at cycle t+2, 16 beats in 16 cycles in order, o_ready continuously 1.
- Same configuration; hold i_ready[0]=0 while sending 6 beats -> 4 accepted, o_ready[0]=0 after the 4th, o_count[0]=4. Release -> beats drain in order, count returns 0, o_idle=1. Lane1 unaffected throughout.
- FULL_BANDWIDTH=0, STAGES=1; constant i_valid, i_ready=1 -> exactly 1 transfer every 2 cycles and o_count alternating 1/0.
- 3 beats in flight on lane1, then i_flush=1 for 1 cycle with i_valid=1 and i_ready=0 -> next cycle o_valid=0, o_count=0, the input beat is not accepted; the following beat passes normally.
- Assert i_rst for 1 cycle mid-stream with 4 beats buffered -> o_valid=0, o_count=0 and o_ready=0 during reset, o_ready=1 after; none of the old payloads appear afterwards.
- Random valid/ready on 4 lanes for 10k cycles against a scoreboard -> no loss, duplication or reorder; o_data stable during stalls; count bounds hold.
